// File: rtl/foo_pkg.sv
// Shared types for the two-lane foo result path: the captured pair and the lane selector.
package foo_pkg;

    localparam int unsigned FOO_WIDTH = 64;

    typedef struct packed {
        logic [FOO_WIDTH-1:0] x0;
        logic [FOO_WIDTH-1:0] x1;
    } foo_pair_t;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } foo_lane_e;

endpackage

// File: rtl/foo_pair_fifo.sv
// Synchronous FIFO of x0/x1 result pairs with head-of-queue read.
module foo_pair_fifo
    import foo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  foo_pair_t push_data_i,
    input  logic      pop_i,
    output foo_pair_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    foo_pair_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push;
    logic            pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is written only on a real push, so undriven inputs never land in it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/foo_lane_merge.sv
// Serialises buffered x0/x1 pairs onto one beat stream (lane 0 then lane 1) and keeps
// a running XOR fold and beat count of every accepted beat.
module foo_lane_merge
    import foo_pkg::*;
#(
    parameter int unsigned WIDTH = FOO_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_x0_i,
    input  logic [WIDTH-1:0] in_x1_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_lane_o,
    output logic [WIDTH-1:0] fold_o,
    output logic [31:0]      beat_cnt_o
);

    foo_lane_e        lane_q, lane_d;
    logic [WIDTH-1:0] fold_q, fold_d;
    logic [31:0]      beat_cnt_q, beat_cnt_d;
    foo_pair_t        push_pair;
    foo_pair_t        head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;

    assign push_pair = '{x0: in_x0_i, x1: in_x1_i};

    foo_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (in_valid_i),
        .push_data_i (push_pair),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        in_ready_o  = !full;
        out_valid_o = !empty;
        out_lane_o  = lane_q;
        out_data_o  = '0;
        if (!empty) begin
            out_data_o = (lane_q == LANE1) ? head.x1 : head.x0;
        end
        accept     = out_valid_o && out_ready_i;
        pop        = accept && (lane_q == LANE1);
        lane_d     = lane_q;
        fold_d     = fold_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            lane_d     = (lane_q == LANE0) ? LANE1 : LANE0;
            fold_d     = fold_q ^ out_data_o;
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lane_q     <= LANE0;
            fold_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            lane_q     <= lane_d;
            fold_q     <= fold_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign fold_o     = fold_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_foo_lane_merge.sv
// Bench for foo_lane_merge: directed scenarios plus random traffic against a beat-queue model.
module tb_foo_lane_merge;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x0;
    logic [WIDTH-1:0] in_x1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_lane;
    logic [WIDTH-1:0] fold;
    logic [31:0]      beat_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             lane;
    } beat_t;

    beat_t            mq[$];
    logic [WIDTH-1:0] m_fold = '0;
    logic [31:0]      m_cnt = '0;
    bit               m_live = 1'b0;

    foo_lane_merge #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_x0_i     (in_x0),
        .in_x1_i     (in_x1),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_lane_o  (out_lane),
        .fold_o      (fold),
        .beat_cnt_o  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pairs still held = beats outstanding rounded up to whole pairs.
    function automatic bit m_in_ready();
        return ((mq.size() + 1) / 2) < DEPTH;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance through the rising edge, update the model.
    task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit rdy, input bit rn = 1'b1);
        bit acc;
        bit psh;
        rst_n     = rn;
        in_valid  = v;
        in_x0     = v ? a : {$urandom(), $urandom()};
        in_x1     = v ? b : {$urandom(), $urandom()};
        out_ready = rdy;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_fold = '0;
            m_cnt  = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            acc = (mq.size() != 0) && rdy;
            psh = v && m_in_ready();
            if (acc) begin
                m_fold = m_fold ^ mq[0].data;
                m_cnt  = m_cnt + 32'd1;
                void'(mq.pop_front());
            end
            if (psh) begin
                mq.push_back('{data: a, lane: 1'b0});
                mq.push_back('{data: b, lane: 1'b1});
            end
        end
        #1;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Continuous comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_live) begin
            chk("out_valid", {63'b0, out_valid}, {63'b0, mq.size() != 0});
            chk("in_ready", {63'b0, in_ready}, {63'b0, m_in_ready()});
            chk("out_data", out_data, (mq.size() != 0) ? mq[0].data : '0);
            chk("out_lane", {63'b0, out_lane}, {63'b0, (mq.size() != 0) ? mq[0].lane : 1'b0});
            chk("fold", fold, m_fold);
            chk("beat_cnt", {32'b0, beat_cnt}, {32'b0, m_cnt});
        end
    end

    logic [WIDTH-1:0] exp_fill [8];
    logic [WIDTH-1:0] seen [$];
    logic [WIDTH-1:0] prev_data;
    logic             prev_lane;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_x0 = '0; in_x1 = '0; out_ready = 1'b0;

        // Reset state
        reset_cycles(2);
        @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_fold", fold, 64'd0);
        chk("rst_beat_cnt", {32'b0, beat_cnt}, 64'd0);
        chk("rst_out_lane", {63'b0, out_lane}, 64'd0);

        // Single pair
        step(1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1);
        @(negedge clk);
        chk("single_b0", out_data, 64'h1111_1111_1111_1111);
        chk("single_l0", {63'b0, out_lane}, 64'd0);
        step(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("single_b1", out_data, 64'h2222_2222_2222_2222);
        chk("single_l1", {63'b0, out_lane}, 64'd1);
        step(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("single_done", {63'b0, out_valid}, 64'd0);
        chk("single_fold", fold, 64'h3333_3333_3333_3333);
        chk("single_cnt", {32'b0, beat_cnt}, 64'd2);

        // Fill and backpressure
        reset_cycles(1);
        for (int k = 1; k <= 4; k++) step(1'b1, 64'(k), 64'(256 + k), 1'b0);
        @(negedge clk);
        chk("fill_in_ready", {63'b0, in_ready}, 64'd0);
        step(1'b1, 64'd5, 64'h105, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_fill[2*k]   = 64'(k + 1);
            exp_fill[2*k+1] = 64'(257 + k);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fill_beat", out_data, exp_fill[i]);
            step(1'b0, '0, '0, 1'b1);
        end
        @(negedge clk);
        chk("fill_empty", {63'b0, out_valid}, 64'd0);
        chk("fill_cnt", {32'b0, beat_cnt}, 64'd8);
        chk("fill_fold", fold, 64'd0);

        // Stall stability during a 3-pair drain
        reset_cycles(1);
        for (int k = 0; k < 3; k++) step(1'b1, 64'(32 + k), 64'(48 + k), 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i % 2 == 1 && out_valid) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_lane", {63'b0, out_lane}, {63'b0, prev_lane});
            end
            prev_data = out_data;
            prev_lane = out_lane;
            step(1'b0, '0, '0, (i % 2) == 1);
        end
        @(negedge clk);
        chk("stall_cnt", {32'b0, beat_cnt}, 64'd6);

        // Full plus pop on the same edge
        reset_cycles(1);
        for (int k = 1; k <= 4; k++) step(1'b1, 64'(16 + k), 64'(32 + k), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b1, 64'hAA, 64'hBB, 1'b1);
        @(negedge clk);
        chk("fullpop_in_ready", {63'b0, in_ready}, 64'd1);
        chk("fullpop_lane", {63'b0, out_lane}, 64'd0);
        step(1'b1, 64'hAA, 64'hBB, 1'b1);
        seen.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen.push_back(out_data);
            step(1'b0, '0, '0, 1'b1);
        end
        chk("fullpop_n", 64'(seen.size()), 64'd7);
        if (seen.size() >= 2) begin
            chk("fullpop_aa", seen[seen.size()-2], 64'hAA);
            chk("fullpop_bb", seen[seen.size()-1], 64'hBB);
        end

        // Mid-stream reset
        reset_cycles(1);
        step(1'b1, 64'hA1, 64'hB1, 1'b0);
        step(1'b1, 64'hA2, 64'hB2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_out_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_lane", {63'b0, out_lane}, 64'd0);
        chk("mid_fold", fold, 64'd0);
        chk("mid_cnt", {32'b0, beat_cnt}, 64'd0);
        step(1'b1, 64'h5, 64'h6, 1'b1);
        @(negedge clk);
        chk("mid_b0", out_data, 64'h5);
        chk("mid_l0", {63'b0, out_lane}, 64'd0);
        step(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("mid_b1", out_data, 64'h6);
        chk("mid_l1", {63'b0, out_lane}, 64'd1);

        // Random traffic with varying load and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) != 0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 299) != 0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
